// File: rtl/rr_operand_pipe_if.sv
// Issue / PRF / bypass / execute signal bundle for rr_operand_pipe.
// laneActive exists only when RR_LANE_GATING_EN is defined.
interface rr_operand_pipe_if #(
  parameter int NUM_LANES = 2,
  parameter int NUM_BYP   = 2,
  parameter int DATA_W    = 64,
  parameter int PREG_LOG  = 7,
  parameter int PAYLOAD_W = 32
);
  logic                           flush;
  logic [NUM_LANES-1:0]           issValid;
  logic                           issReady;
  logic [NUM_LANES*PREG_LOG-1:0]  issSrc1;
  logic [NUM_LANES*PREG_LOG-1:0]  issSrc2;
  logic [NUM_LANES*PAYLOAD_W-1:0] issPayload;
  logic [NUM_LANES*PREG_LOG-1:0]  prfSrc1Addr;
  logic [NUM_LANES*PREG_LOG-1:0]  prfSrc2Addr;
  logic [NUM_LANES*DATA_W-1:0]    prfSrc1Data;
  logic [NUM_LANES*DATA_W-1:0]    prfSrc2Data;
  logic [NUM_BYP-1:0]             bypValid;
  logic [NUM_BYP*PREG_LOG-1:0]    bypTag;
  logic [NUM_BYP*DATA_W-1:0]      bypData;
  logic [NUM_LANES-1:0]           exeValid;
  logic                           exeReady;
  logic [NUM_LANES*DATA_W-1:0]    exeSrc1;
  logic [NUM_LANES*DATA_W-1:0]    exeSrc2;
  logic [NUM_LANES*PAYLOAD_W-1:0] exePayload;
  logic                           validBundle;
`ifdef RR_LANE_GATING_EN
  logic [NUM_LANES-1:0]           laneActive;
`endif

  modport master (
`ifdef RR_LANE_GATING_EN
    output laneActive,
`endif
    output flush, issValid, issSrc1, issSrc2, issPayload,
    output prfSrc1Data, prfSrc2Data, bypValid, bypTag, bypData, exeReady,
    input  issReady, prfSrc1Addr, prfSrc2Addr, exeValid, exeSrc1, exeSrc2,
    input  exePayload, validBundle
  );

  modport slave (
`ifdef RR_LANE_GATING_EN
    input  laneActive,
`endif
    input  flush, issValid, issSrc1, issSrc2, issPayload,
    input  prfSrc1Data, prfSrc2Data, bypValid, bypTag, bypData, exeReady,
    output issReady, prfSrc1Addr, prfSrc2Addr, exeValid, exeSrc1, exeSrc2,
    output exePayload, validBundle
  );
endinterface

// File: rtl/rr_operand_pipe.sv
// Multi-lane register-read pipeline: issue latch, PRF capture, bypass snooping, execute handoff.
// Optional per-lane gating is enabled with the RR_LANE_GATING_EN macro.
module rr_operand_pipe #(
  parameter int NUM_LANES = 2,
  parameter int NUM_BYP   = 2,
  parameter int RR_DEPTH  = 2,
  parameter int DATA_W    = 64,
  parameter int PREG_LOG  = 7,
  parameter int PAYLOAD_W = 32
) (
  input logic              clk,
  input logic              reset,
  rr_operand_pipe_if.slave bus
);
  localparam int LAST = RR_DEPTH - 1;

  logic                        stall;
  logic                        transfer;
  logic [NUM_LANES-1:0]        laneEn;
  logic [NUM_LANES-1:0]        laneBusy;
  logic [NUM_BYP-1:0]          bypValid;
  logic [NUM_BYP*PREG_LOG-1:0] bypTag;
  logic [NUM_BYP*DATA_W-1:0]   bypData;

  assign bypValid = bus.bypValid;
  assign bypTag   = bus.bypTag;
  assign bypData  = bus.bypData;

`ifdef RR_LANE_GATING_EN
  assign laneEn = bus.laneActive;
`else
  assign laneEn = '1;
`endif

  assign stall           = |(bus.exeValid & ~{NUM_LANES{bus.exeReady}});
  assign bus.issReady    = ~stall;
  assign transfer        = ~stall & (|(bus.issValid & laneEn));
  assign bus.validBundle = |laneBusy;

  // Scanning from the highest channel down lets the lowest matching channel win.
  function automatic logic [DATA_W-1:0] snoop(input logic [PREG_LOG-1:0] tag,
                                              input logic [DATA_W-1:0]   cur);
    snoop = cur;
    for (int b = NUM_BYP - 1; b >= 0; b--) begin
      if (bypValid[b] && bypTag[b*PREG_LOG +: PREG_LOG] == tag)
        snoop = bypData[b*DATA_W +: DATA_W];
    end
  endfunction

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [RR_DEPTH-1:0]  validReg;
    logic [PREG_LOG-1:0]  tag1Reg    [RR_DEPTH];
    logic [PREG_LOG-1:0]  tag2Reg    [RR_DEPTH];
    logic [PAYLOAD_W-1:0] payloadReg [RR_DEPTH];
    logic [DATA_W-1:0]    src1Reg    [1:LAST];
    logic [DATA_W-1:0]    src2Reg    [1:LAST];
    logic [DATA_W-1:0]    prf1Data;
    logic [DATA_W-1:0]    prf2Data;

    assign prf1Data = bus.prfSrc1Data[gi*DATA_W +: DATA_W];
    assign prf2Data = bus.prfSrc2Data[gi*DATA_W +: DATA_W];

    // Flush and lane deactivation win over stall; bubbles shift along like packets.
    always_ff @(posedge clk) begin
      if (reset || bus.flush || !laneEn[gi])
        validReg <= '0;
      else if (!stall)
        validReg <= {validReg[RR_DEPTH-2:0], bus.issValid[gi]};
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s < RR_DEPTH; s++) begin
          tag1Reg[s]    <= '0;
          tag2Reg[s]    <= '0;
          payloadReg[s] <= '0;
        end
        for (int s = 1; s < RR_DEPTH; s++) begin
          src1Reg[s] <= '0;
          src2Reg[s] <= '0;
        end
      end else if (laneEn[gi]) begin
        if (stall) begin
          for (int s = 1; s < RR_DEPTH; s++) begin
            src1Reg[s] <= snoop(tag1Reg[s], src1Reg[s]);
            src2Reg[s] <= snoop(tag2Reg[s], src2Reg[s]);
          end
        end else begin
          if (transfer) begin
            tag1Reg[0]    <= bus.issSrc1[gi*PREG_LOG +: PREG_LOG];
            tag2Reg[0]    <= bus.issSrc2[gi*PREG_LOG +: PREG_LOG];
            payloadReg[0] <= bus.issPayload[gi*PAYLOAD_W +: PAYLOAD_W];
          end
          src1Reg[1] <= snoop(tag1Reg[0], prf1Data);
          src2Reg[1] <= snoop(tag2Reg[0], prf2Data);
          for (int s = 1; s < RR_DEPTH; s++) begin
            tag1Reg[s]    <= tag1Reg[s-1];
            tag2Reg[s]    <= tag2Reg[s-1];
            payloadReg[s] <= payloadReg[s-1];
          end
          for (int s = 2; s < RR_DEPTH; s++) begin
            src1Reg[s] <= snoop(tag1Reg[s-1], src1Reg[s-1]);
            src2Reg[s] <= snoop(tag2Reg[s-1], src2Reg[s-1]);
          end
        end
      end
    end

    assign bus.exeValid[gi]                          = validReg[LAST];
    assign bus.exeSrc1[gi*DATA_W +: DATA_W]          = src1Reg[LAST];
    assign bus.exeSrc2[gi*DATA_W +: DATA_W]          = src2Reg[LAST];
    assign bus.exePayload[gi*PAYLOAD_W +: PAYLOAD_W] = payloadReg[LAST];
    assign bus.prfSrc1Addr[gi*PREG_LOG +: PREG_LOG]  = tag1Reg[0];
    assign bus.prfSrc2Addr[gi*PREG_LOG +: PREG_LOG]  = tag2Reg[0];
    assign laneBusy[gi]                              = (|validReg) & laneEn[gi];
  end
endmodule

// File: tb/tb_rr_operand_pipe.sv
// Directed and random checks of rr_operand_pipe against a timestamp-based packet model.
// Lane gating stimulus is compiled in when RR_LANE_GATING_EN is defined.
module tb_rr_operand_pipe;
  localparam int NL = 2;
  localparam int NB = 2;
  localparam int D  = 2;
  localparam int DW = 64;
  localparam int PL = 7;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_operand_pipe_if #(.NUM_LANES(NL), .NUM_BYP(NB), .DATA_W(DW), .PREG_LOG(PL), .PAYLOAD_W(PW)) bus ();

  rr_operand_pipe #(.NUM_LANES(NL), .NUM_BYP(NB), .RR_DEPTH(D), .DATA_W(DW), .PREG_LOG(PL),
                    .PAYLOAD_W(PW)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [DW-1:0] prf [128];
  logic [NL-1:0] act;
`ifdef RR_LANE_GATING_EN
  assign bus.laneActive = act;
`endif

  // Register file model: data appears in the same cycle the pipe presents an address.
  always_comb begin
    bus.prfSrc1Data = '0;
    bus.prfSrc2Data = '0;
    for (int l = 0; l < NL; l++) begin
      bus.prfSrc1Data[l*DW +: DW] = prf[bus.prfSrc1Addr[l*PL +: PL]];
      bus.prfSrc2Data[l*DW +: DW] = prf[bus.prfSrc2Addr[l*PL +: PL]];
    end
  end

  // A packet's position is its age in advancing cycles since it was issued.
  typedef struct {
    int                    born;
    logic [NL-1:0]         lanes;
    logic [NL-1:0][PL-1:0] t1;
    logic [NL-1:0][PL-1:0] t2;
    logic [NL-1:0][DW-1:0] v1;
    logic [NL-1:0][DW-1:0] v2;
    logic [NL-1:0][PW-1:0] pay;
  } pkt_t;

  pkt_t q[$];
  int   tick;
  int   nAsserts;
  int   nFails;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Newest value of a register as seen on the bypass network this cycle.
  function automatic logic [DW-1:0] bypVal(input logic [PL-1:0] tag, input logic [DW-1:0] cur);
    for (int b = 0; b < NB; b++)
      if (bus.bypValid[b] && bus.bypTag[b*PL +: PL] == tag) return bus.bypData[b*DW +: DW];
    return cur;
  endfunction

  task automatic step();
    int            ex;
    logic [NL-1:0] expExe;
    logic          stall;
    logic          busy;
    pkt_t          p;
    @(negedge clk);
    ex   = -1;
    busy = 1'b0;
    foreach (q[i]) begin
      if (tick - q[i].born == D - 1) ex = i;
      if ((q[i].lanes & act) != '0) busy = 1'b1;
    end
    expExe = (ex >= 0) ? q[ex].lanes : '0;
    stall  = |(expExe & ~{NL{bus.exeReady}});
    chk("issReady", 64'(bus.issReady), 64'(!stall));
    chk("exeValid", 64'(bus.exeValid), 64'(expExe));
    chk("validBundle", 64'(bus.validBundle), 64'(busy));
    for (int l = 0; l < NL; l++) begin
      if (expExe[l]) begin
        chk($sformatf("src1_lane%0d", l), bus.exeSrc1[l*DW +: DW], q[ex].v1[l]);
        chk($sformatf("src2_lane%0d", l), bus.exeSrc2[l*DW +: DW], q[ex].v2[l]);
        chk($sformatf("payload_lane%0d", l), 64'(bus.exePayload[l*PW +: PW]), 64'(q[ex].pay[l]));
      end
    end
    if (reset) begin
      q.delete();
    end else begin
      for (int i = 0; i < q.size(); i++) begin
        p = q[i];
        for (int l = 0; l < NL; l++) begin
          if (tick - p.born >= 1) begin
            p.v1[l] = bypVal(p.t1[l], p.v1[l]);
            p.v2[l] = bypVal(p.t2[l], p.v2[l]);
          end else if (!stall) begin
            p.v1[l] = bypVal(p.t1[l], prf[p.t1[l]]);
            p.v2[l] = bypVal(p.t2[l], prf[p.t2[l]]);
          end
        end
        q[i] = p;
      end
      if (bus.flush) begin
        q.delete();
      end else if (!stall) begin
        if (ex >= 0) q.delete(ex);
        tick++;
        if ((bus.issValid & act) != '0) begin
          p.born  = tick;
          p.lanes = bus.issValid & act;
          p.v1    = '0;
          p.v2    = '0;
          for (int l = 0; l < NL; l++) begin
            p.t1[l]  = bus.issSrc1[l*PL +: PL];
            p.t2[l]  = bus.issSrc2[l*PL +: PL];
            p.pay[l] = bus.issPayload[l*PW +: PW];
          end
          q.push_back(p);
        end
      end
      for (int i = 0; i < q.size(); i++) begin
        p = q[i];
        p.lanes = p.lanes & act;
        q[i] = p;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset          = 1'b0;
    bus.flush      = 1'b0;
    bus.issValid   = '0;
    bus.bypValid   = '0;
    bus.exeReady   = 1'b1;
  endtask

  task automatic issue(input logic [NL-1:0] m, input logic [PL-1:0] a1, input logic [PL-1:0] a2,
                       input logic [PL-1:0] b1, input logic [PL-1:0] b2);
    bus.issValid   = m;
    bus.issSrc1    = {b1, a1};
    bus.issSrc2    = {b2, a2};
    bus.issPayload = {$urandom, $urandom};
  endtask

  task automatic bypass(input int ch, input logic [PL-1:0] tag, input logic [DW-1:0] data);
    bus.bypValid[ch]          = 1'b1;
    bus.bypTag[ch*PL +: PL]   = tag;
    bus.bypData[ch*DW +: DW]  = data;
  endtask

  initial begin
    nAsserts = 0;
    nFails   = 0;
    tick     = 0;
    act      = '1;
    for (int i = 0; i < 128; i++) prf[i] = {$urandom, $urandom};
    prf[5] = 64'h11;
    prf[9] = 64'h22;
    idle();
    bus.issSrc1 = '0; bus.issSrc2 = '0; bus.issPayload = '0;
    bus.bypTag  = '0; bus.bypData = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_exeValid", 64'(bus.exeValid), 64'd0);
    chk("rst_issReady", 64'(bus.issReady), 64'd1);
    chk("rst_validBundle", 64'(bus.validBundle), 64'd0);
    chk("rst_src1_lane0", bus.exeSrc1[63:0], 64'd0);
    chk("rst_src2_lane1", bus.exeSrc2[127:64], 64'd0);
    chk("rst_payload", bus.exePayload, 64'd0);

    // Basic read
    issue(2'b01, 5, 9, 0, 0); step(); idle(); step();
    chk("basic_exeValid", 64'(bus.exeValid), 64'h1);
    chk("basic_src1", bus.exeSrc1[63:0], 64'h11);
    chk("basic_src2", bus.exeSrc2[63:0], 64'h22);
    step();

    // Bypass beats PRF on capture
    issue(2'b01, 5, 9, 0, 0); step(); idle(); bypass(0, 5, 64'hAA); step(); idle();
    chk("bypcap_src1", bus.exeSrc1[63:0], 64'hAA);
    chk("bypcap_src2", bus.exeSrc2[63:0], 64'h22);
    step();

    // Snoop while stalled at execute
    issue(2'b01, 5, 9, 0, 0); step(); idle(); step();
    bus.exeReady = 1'b0; step();
    chk("stall_issReady1", 64'(bus.issReady), 64'd0);
    bypass(1, 9, 64'h55); step();
    chk("stall_issReady2", 64'(bus.issReady), 64'd0);
    bus.bypValid = '0; step();
    chk("stall_issReady3", 64'(bus.issReady), 64'd0);
    chk("stall_src2", bus.exeSrc2[63:0], 64'h55);
    bus.exeReady = 1'b1; step();

    // Lowest bypass channel wins
    issue(2'b01, 5, 9, 0, 0); step(); idle(); bypass(0, 5, 64'h1); bypass(1, 5, 64'h2); step(); idle();
    chk("prio_src1", bus.exeSrc1[63:0], 64'h1);
    step();

    // Flush with a full pipe and a simultaneous issue
    issue(2'b11, 1, 2, 3, 4); step(); issue(2'b11, 5, 6, 7, 8); step();
    bus.flush = 1'b1; issue(2'b11, 9, 10, 11, 12); step(); idle();
    chk("flush_exeValid", 64'(bus.exeValid), 64'd0);
    chk("flush_validBundle", 64'(bus.validBundle), 64'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("flush_after", 64'(bus.exeValid), 64'd0);
    end

`ifdef RR_LANE_GATING_EN
    act = 2'b01;
    issue(2'b11, 5, 9, 5, 9); step(); idle(); step();
    chk("gate_exeValid", 64'(bus.exeValid), 64'h1);
    chk("gate_validBundle", 64'(bus.validBundle), 64'd1);
    step();
    act = 2'b11;
`endif

    // Random traffic with stalls, flushes, occasional resets and heavy tag reuse
    for (int c = 0; c < 400; c++) begin
      bus.issValid = NL'($urandom_range(0, 3));
      for (int l = 0; l < NL; l++) begin
        bus.issSrc1[l*PL +: PL]    = PL'($urandom_range(0, 15));
        bus.issSrc2[l*PL +: PL]    = PL'($urandom_range(0, 15));
        bus.issPayload[l*PW +: PW] = $urandom;
      end
      bus.bypValid = NB'($urandom_range(0, 3));
      for (int b = 0; b < NB; b++) begin
        bus.bypTag[b*PL +: PL]  = PL'($urandom_range(0, 15));
        bus.bypData[b*DW +: DW] = {$urandom, $urandom};
      end
      bus.exeReady = ($urandom_range(0, 3) != 0);
      bus.flush    = ($urandom_range(0, 29) == 0);
      reset        = ($urandom_range(0, 99) == 0);
`ifdef RR_LANE_GATING_EN
      act = ($urandom_range(0, 9) == 0) ? NL'($urandom_range(0, 3)) : '1;
`endif
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
